order_sink: RTL and testbench
=============================

# order_sink

PS-side counterpart of the receive unit. It turns PS order requests into single-cycle `order_come` pulses, throttled by `order_full`. It captures every sample presented while `sending` is high into a capture FIFO that the PS reads. It counts complete orders of ORDER_IMGS samples and raises a sticky error on dropped requests or dropped samples.

## Interface
- FIFO_DATA, 25, sample width (matches receive unit AXI output)
- ORDER_IMGS, 50, samples per complete order
- DEPTH, 64, capture FIFO depth, power of two
- AW, 6, log2(DEPTH)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_order  in  1  PS request pulse, one order per high cycle
- order_full  in  1  receive unit cannot accept orders
- no_order  in  1  receive unit has no pending orders (status only)
- sending  in  1  receive unit transfer active; axi_in valid
- axi_in  in  FIFO_DATA  sample from receive unit
- order_come  out  1  order pulse to receive unit
- rd_en  in  1  PS read strobe
- rd_data  out  FIFO_DATA  read sample
- rd_valid  out  1  rd_data valid
- fifo_count  out  AW+1  capture FIFO occupancy, 0..DEPTH
- pending  out  3  requests not yet issued, 0..7
- orders_done  out  8  completed orders, wraps 255->0
- ord_err  out  1  sticky error
- err_clr  in  1  clears ord_err

## Operation
- Request counter `pending`:
  - +1 on req_order, −1 when order_come is issued; simultaneous req_order and issue leaves it unchanged.
  - At 7, a further req_order is dropped and sets ord_err.
- Issue FSM, states IDLE, ISSUE, HOLD:
  - IDLE -> ISSUE when pending>0 and !order_full; order_come=1 only in ISSUE.
  - ISSUE -> HOLD unconditionally. HOLD covers the one-cycle lag before order_full updates.
  - HOLD -> IDLE unconditionally.
- Capture:
  - Each cycle with sending=1 writes axi_in to the FIFO.
  - The write is accepted if FIFO not full, or if full with rd_en in the same cycle. Otherwise the sample is dropped and ord_err is set.
  - cap_cnt (6 bits) increments per sample, accepted or dropped. At ORDER_IMGS−1 it wraps to 0 and orders_done increments.
  - sending falling mid-order holds cap_cnt; capture resumes on the next sending=1.
- Read:
  - rd_en on a non-empty FIFO pops the head into rd_data; rd_valid=1 for the next cycle.
  - rd_en on an empty FIFO is ignored: rd_valid=0, rd_data holds.
- Error: ord_err is set by a dropped request or a dropped sample and cleared by err_clr. A set and err_clr in the same cycle leaves it set.
- no_order is not used by control logic. A bench checks it equals (pending==0 and FIFO idle) at order boundaries.

## Timing
- Reset: order_come, rd_valid, ord_err = 0; rd_data, fifo_count, pending, orders_done, cap_cnt = 0; FSM IDLE; FIFO empty. Reset mid-order discards FIFO contents and counts.
- req_order sampled at edge k: pending=1 after k; order_come high during the cycle after edge k+1.
- order_come pulses are at least 3 cycles apart (ISSUE, HOLD, IDLE). order_full is sampled only in IDLE.
- Capture: axi_in and sending are sampled on the same edge. fifo_count reflects the write one cycle later.
- Read latency is 1 cycle, rd_en -> rd_valid/rd_data. Simultaneous read and write keeps fifo_count constant.
- orders_done updates on the edge that writes sample ORDER_IMGS−1.

## Structure
- Shared package `us_pkg`:
  - FIFO_DATA and ORDER_IMGS, shared with the receive unit
  - issue FSM state enum
  - MAX_PENDING=7
- Sub-module `cap_fifo`: synchronous single-clock FIFO with full/empty/count and registered read; parameters FIFO_DATA, DEPTH.
- Top level holds the request counter, issue FSM, capture counter and error logic.

## Test plan
- Single order: req_order 1 cycle, then sending=1 for 50 cycles with axi_in=0..49 -> one order_come pulse 2 edges after the request; fifo_count=50; orders_done=1; PS reads return 0..49 in order.
- Throttle: 3 requests with order_full=1 -> no order_come, pending=3; release order_full -> 3 pulses spaced 3 cycles apart, pending ends at 0.
- Saturation: 8 requests with order_full=1 -> pending=7, ord_err=1; err_clr -> ord_err=0.
- Overflow: 70 samples, no reads -> fifo_count=64, ord_err=1, orders_done=1, cap_cnt=20; rd_en plus write while full keeps count at 64.
- Interrupted order: sending high 30, low 10, high 20 -> orders_done=1 only after sample 50.
- Reset mid-capture at sample 25 -> all outputs 0; the next 50 samples give orders_done=1.

Source files
------------

// File: rtl/us_pkg.sv
// Shared definitions for the receive unit and its PS-side order sink:
// sample width, order length, request limit and the issue FSM encoding.
package us_pkg;

    localparam int FIFO_DATA   = 25;
    localparam int ORDER_IMGS  = 50;
    localparam int MAX_PENDING = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } issue_state_t;

endpackage

// File: rtl/order_sink_cap_fifo.sv
// Single-clock capture FIFO with registered read. A write while full is
// still accepted when a read happens in the same cycle, because the head
// slot is freed on that edge.
module cap_fifo #(
    parameter int FIFO_DATA = 25,
    parameter int DEPTH     = 64,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [FIFO_DATA-1:0] wr_data,
    input  logic                 rd_en,
    output logic [FIFO_DATA-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic [AW:0]          count
);

    logic [FIFO_DATA-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 push;
    logic                 pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign pop   = rd_en && !empty;
    assign push  = wr_en && (!full || rd_en);

    // Sample storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered read port; rd_data holds when nothing is popped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: rtl/order_sink.sv
// PS-side order sink: turns PS requests into spaced order_come pulses,
// captures streamed samples into a FIFO for the PS, counts complete
// orders and flags dropped requests or samples in a sticky error.
module order_sink
    import us_pkg::*;
#(
    parameter int FIFO_DATA  = us_pkg::FIFO_DATA,
    parameter int ORDER_IMGS = us_pkg::ORDER_IMGS,
    parameter int DEPTH      = 64,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_order,
    input  logic                 order_full,
    input  logic                 no_order,
    input  logic                 sending,
    input  logic [FIFO_DATA-1:0] axi_in,
    output logic                 order_come,
    input  logic                 rd_en,
    output logic [FIFO_DATA-1:0] rd_data,
    output logic                 rd_valid,
    output logic [AW:0]          fifo_count,
    output logic [2:0]           pending,
    output logic [7:0]           orders_done,
    output logic                 ord_err,
    input  logic                 err_clr
);

    issue_state_t state;
    issue_state_t state_nxt;
    logic         issue;
    logic         req_drop;
    logic         req_take;
    logic         fifo_full;
    logic         fifo_empty;
    logic         sample_drop;
    logic [5:0]   cap_cnt;

    // no_order is status for the PS only; fifo emptiness is implied by count
    logic unused_status;
    assign unused_status = ^{no_order, fifo_empty};

    assign issue       = (state == ST_ISSUE);
    assign req_drop    = req_order && (pending == 3'(MAX_PENDING)) && !issue;
    assign req_take    = req_order && !req_drop;
    assign sample_drop = sending && fifo_full && !rd_en;

    // Outstanding request counter; an issue in the same cycle makes room
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            case ({req_take, issue})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
        end
    end

    // Issue FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Issue FSM next state; HOLD covers the lag before order_full reacts
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if ((pending != '0) && !order_full) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_HOLD;
            ST_HOLD:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Issue FSM outputs
    always_comb begin
        order_come = 1'b0;
        if (state == ST_ISSUE) begin
            order_come = 1'b1;
        end
    end

    // Capture position within the current order; dropped samples still count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_cnt     <= '0;
            orders_done <= '0;
        end else if (sending) begin
            if (cap_cnt == 6'(ORDER_IMGS - 1)) begin
                cap_cnt     <= '0;
                orders_done <= orders_done + 1'b1;
            end else begin
                cap_cnt <= cap_cnt + 1'b1;
            end
        end
    end

    // Sticky error; a new fault wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ord_err <= 1'b0;
        end else if (req_drop || sample_drop) begin
            ord_err <= 1'b1;
        end else if (err_clr) begin
            ord_err <= 1'b0;
        end
    end

    cap_fifo #(
        .FIFO_DATA (FIFO_DATA),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_cap_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (sending),
        .wr_data  (axi_in),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_order_sink.sv
// Randomized scoreboard bench for order_sink with a queue-based reference.
module tb_order_sink;

    localparam int FIFO_DATA  = 25;
    localparam int ORDER_IMGS = 50;
    localparam int DEPTH      = 64;
    localparam int AW         = 6;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 req_order = 1'b0;
    logic                 order_full = 1'b0;
    logic                 no_order = 1'b0;
    logic                 sending = 1'b0;
    logic [FIFO_DATA-1:0] axi_in = '0;
    logic                 order_come;
    logic                 rd_en = 1'b0;
    logic [FIFO_DATA-1:0] rd_data;
    logic                 rd_valid;
    logic [AW:0]          fifo_count;
    logic [2:0]           pending;
    logic [7:0]           orders_done;
    logic                 ord_err;
    logic                 err_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [FIFO_DATA-1:0] m_q[$];
    logic [FIFO_DATA-1:0] sb[$];
    logic [FIFO_DATA-1:0] m_rd;
    int m_pending, m_cap, m_orders, m_gap;
    bit m_err, m_come;

    order_sink #(
        .FIFO_DATA (FIFO_DATA),
        .ORDER_IMGS(ORDER_IMGS),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_order  (req_order),
        .order_full (order_full),
        .no_order   (no_order),
        .sending    (sending),
        .axi_in     (axi_in),
        .order_come (order_come),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fifo_count (fifo_count),
        .pending    (pending),
        .orders_done(orders_done),
        .ord_err    (ord_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        sb.delete();
        m_rd      = '0;
        m_pending = 0;
        m_cap     = 0;
        m_orders  = 0;
        m_gap     = 3;
        m_err     = 1'b0;
        m_come    = 1'b0;
    endfunction

    task automatic chk_state();
        chk("fifo_count", int'(fifo_count), m_q.size());
        chk("pending", int'(pending), m_pending);
        chk("orders_done", int'(orders_done), m_orders);
        chk("ord_err", int'(ord_err), int'(m_err));
    endtask

    // advance one clock, update the reference from the sampled inputs
    task automatic tick();
        bit issuing, dropq, drops, pop;
        int pend_old;
        @(posedge clk);
        if (rst_n) begin
            issuing  = m_come;
            pend_old = m_pending;
            m_gap++;
            // a new pulse needs an idle look: three edges after the last one
            m_come = (m_gap >= 3) && (pend_old > 0) && !order_full;
            if (m_come) m_gap = 0;
            dropq = req_order && (pend_old == 7) && !issuing;
            m_pending = pend_old + ((req_order && !dropq) ? 1 : 0) - (issuing ? 1 : 0);
            pop = rd_en && (m_q.size() > 0);
            if (pop) sb.push_back(m_q.pop_front());
            drops = 1'b0;
            if (sending) begin
                if (m_q.size() < DEPTH) m_q.push_back(axi_in);
                else drops = 1'b1;
                m_cap++;
                if (m_cap == ORDER_IMGS) begin
                    m_cap = 0;
                    m_orders = (m_orders + 1) % 256;
                end
            end
            if (dropq || drops) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
        #1;
        chk_state();
    endtask

    task automatic drive(input bit req, input bit full, input bit send,
                         input logic [FIFO_DATA-1:0] d, input bit rd, input bit clr);
        req_order  = req;
        order_full = full;
        sending    = send;
        axi_in     = d;
        rd_en      = rd;
        err_clr    = clr;
        no_order   = (m_pending == 0) && (m_q.size() == 0);
        tick();
    endtask

    task automatic idle(input int n, input bit full);
        for (int i = 0; i < n; i++) drive(0, full, 0, '0, 0, 0);
    endtask

    task automatic apply_reset(input int cycles);
        req_order = 0; sending = 0; rd_en = 0; err_clr = 0; order_full = 0;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_state();
        chk("reset_order_come", int'(order_come), 0);
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_rd_data", int'(rd_data), 0);
        for (int i = 0; i < cycles; i++) tick();
        rst_n = 1'b1;
    endtask

    // monitor: pulses, read responses and rd_data hold behaviour
    always @(negedge clk) begin
        logic [FIFO_DATA-1:0] exp;
        chk("order_come", int'(order_come), int'(m_come));
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            chk("rd_valid", int'(rd_valid), 1);
            chk("rd_data", int'(rd_data), int'(exp));
            m_rd = exp;
        end else begin
            chk("rd_valid_idle", int'(rd_valid), 0);
            chk("rd_data_hold", int'(rd_data), int'(m_rd));
        end
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        apply_reset(3);

        // single order with ramp data, then read it all back
        drive(1, 0, 0, '0, 0, 0);
        for (int i = 0; i < ORDER_IMGS; i++) drive(0, 0, 1, FIFO_DATA'(i), 0, 0);
        for (int i = 0; i < ORDER_IMGS; i++) drive(0, 0, 0, '0, 1, 0);
        idle(3, 0);

        // throttle: requests held off by order_full, then released
        for (int i = 0; i < 3; i++) drive(1, 1, 0, '0, 0, 0);
        idle(5, 1);
        idle(12, 0);

        // saturation: eighth request dropped, then clear error
        for (int i = 0; i < 8; i++) drive(1, 1, 0, '0, 0, 0);
        drive(0, 1, 0, '0, 0, 1);
        idle(2, 1);
        idle(25, 0);

        // overflow without reads, then read+write while full, then drain
        for (int i = 0; i < 70; i++) drive(0, 0, 1, FIFO_DATA'($urandom), 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, FIFO_DATA'($urandom), 1, 0);
        drive(0, 0, 0, '0, 0, 1);
        for (int i = 0; i < 70; i++) drive(0, 0, 0, '0, 1, 0);

        // reset mid-capture, then a full order
        apply_reset(0);
        for (int i = 0; i < 25; i++) drive(0, 0, 1, FIFO_DATA'($urandom), 0, 0);
        apply_reset(2);
        for (int i = 0; i < ORDER_IMGS; i++) drive(0, 0, 1, FIFO_DATA'($urandom), 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, '0, 1, 0);

        // interrupted order: 30 samples, gap, 20 samples
        for (int i = 0; i < 30; i++) drive(0, 0, 1, FIFO_DATA'($urandom), 1, 0);
        idle(10, 0);
        for (int i = 0; i < 20; i++) drive(0, 0, 1, FIFO_DATA'($urandom), 1, 0);
        idle(3, 0);

        // random traffic
        begin
            bit full_r;
            full_r = 0;
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 9) == 0) full_r = ~full_r;
                drive($urandom_range(0, 5) == 0, full_r, $urandom_range(0, 1) == 1,
                      FIFO_DATA'($urandom), $urandom_range(0, 2) == 0,
                      $urandom_range(0, 31) == 0);
            end
        end
        for (int i = 0; i < 70; i++) drive(0, 0, 0, '0, 1, 0);
        idle(2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
